serial_adder: RTL
=================

Name: serial_adder

Overview:
- Bit-serial ripple adder.
- Accepts two WIDTH-bit operands plus carry-in through a start/ready handshake.
- Adds one bit per clock, LSB first, through a single full-adder cell built from two half-adder cells and a registered carry.
- Sits directly downstream of the half-adder cell as its sequential consumer. It is the team's area-minimal adder for multi-bit operands.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request to begin an addition; sampled only when ready=1
- a  input  WIDTH  operand A; captured on the accepted start edge
- b  input  WIDTH  operand B; captured on the accepted start edge
- cin  input  1  carry-in; captured on the accepted start edge
- ready  output  1  high only in IDLE; block can accept start
- done  output  1  single-cycle pulse; sum and cout are valid
- sum  output  WIDTH  result a+b+cin mod 2^WIDTH
- cout  output  1  carry out of bit WIDTH-1

Behaviour:
- Reset (rst=1 at rising edge, takes priority over everything):
  - state=IDLE, ready=1, done=0, sum=0, cout=0.
  - Shift registers, carry and bit counter cleared.
  - Applies mid-operation: any in-flight addition is discarded and no done is issued.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - If start=1 at an edge: load a_sh=a, b_sh=b, carry=cin, cnt=0; go to RUN.
  - sum/cout keep their previous result; they are not cleared on start.
- RUN:
  - ready=0.
  - Each edge computes s_bit = a_sh[0]^b_sh[0]^carry and c_next = majority(a_sh[0], b_sh[0], carry).
  - a_sh and b_sh shift right by one; s_bit shifts into the MSB of the internal result register; carry updates to c_next; cnt increments.
  - On the edge where cnt==WIDTH-1: last bit processed; sum <= completed result, cout <= c_next; go to DONE.
  - start is ignored in RUN; operand inputs may change freely.
- DONE:
  - done=1, ready=0, for exactly one cycle; unconditional transition to IDLE.
- Latency and throughput:
  - start accepted at edge E0 -> done high in the cycle following edge E0+WIDTH.
  - Next start can be accepted at edge E0+WIDTH+2 at the earliest, giving one addition per WIDTH+2 cycles.
- Hold: sum and cout stay stable from the DONE edge until the next accepted start completes, or until reset.
- Width rules:
  - cnt is $clog2(WIDTH)+1 bits wide, so it does not wrap before the compare for any legal WIDTH.
  - WIDTH=1: RUN lasts one cycle.
- Overflow: result is modular; no saturation; overflow is reported only through cout.
- Simultaneous rst and start: reset wins; start is not accepted.
- No combinational path from inputs to outputs. All outputs are registered or decoded directly from the state register.

Decomposition:
- Package serial_adder_pkg holds:
  - the state enum type (IDLE, RUN, DONE);
  - localparam DEFAULT_WIDTH = 8.
- Sub-module fa_cell (x, y, ci -> s, co):
  - purely combinational;
  - two half-adder cells, with co = c1 | c2;
  - instantiated once in the RUN datapath.
- Everything else stays in serial_adder.

Test Plan:
- WIDTH=8:
  - reset, then a=0x00, b=0x00, cin=0, start pulse -> done one cycle after edge E0+8, sum=0x00, cout=0; ready returns to 1 the cycle after done.
  - a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
  - a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1.
  - a=0x3C, b=0x42, cin=0, then start=1 held with a=0xFF, b=0xFF during RUN -> first result sum=0x7E, cout=0, unaffected by the held start. The held start is accepted only once back in IDLE, after which sum=0xFE, cout=1.
  - rst asserted for one edge after 4 RUN cycles of a=0x12, b=0x34 -> no done pulse; sum=0x00, cout=0, ready=1 on the next cycle; a fresh a=0x12, b=0x34 request then gives sum=0x46.
- WIDTH=1: a=1, b=1, cin=1 -> done one cycle after edge E0+1, sum=1, cout=1.
- Scoreboard all cases against a+b+cin computed at WIDTH+1 bits.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
// Holds the controller state encoding and the default operand width.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fa_cell.sv
// Combinational full adder assembled from two half-adder stages.
// Zero latency; no handshake.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s1;
  logic c1;
  logic c2;

  // First half adder combines the operand bits, second folds in the carry.
  assign s1 = x ^ y;
  assign c1 = x & y;
  assign s  = s1 ^ ci;
  assign c2 = s1 & ci;
  assign co = c1 | c2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one bit per clock LSB first, done pulses WIDTH+1 cycles after start.
// start is only honoured while ready is high; sum/cout hold until the next result lands.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             s_bit;
  logic             c_next;

  fa_cell u_fa (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .ci (carry_q),
    .s  (s_bit),
    .co (c_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
        res_d = res_q >> 1;
        res_d[WIDTH-1] = s_bit;
        carry_d = c_next;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sum_d   = res_d;
          cout_d  = c_next;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ready = (state_q == IDLE);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign cout  = cout_q;

endmodule
